// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: controller handshake, redirect input and instruction-memory port.
// The master modport is the fetch unit's view; slave is the controller/memory side.
interface instr_fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             fetch_start;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [WIDTH-1:0] instr_pc;
  logic [WIDTH-1:0] pc_plus_4;
  logic             busy;
  logic             misaligned;

  modport master (
    input  fetch_start, redirect_valid, redirect_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, pc_plus_4, busy,
           misaligned
  );

  modport slave (
    output fetch_start, redirect_valid, redirect_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, pc_plus_4, busy,
           misaligned
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC and instruction register, runs the
// req/ack handshake with instruction memory and absorbs jump redirects, including
// ones that land while a request is still outstanding.
module instr_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StFlush, StTrap} state_e;

  localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);
  localparam logic [31:0]      Nop    = 32'h0000_0013;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] eff;
  logic             eff_misal;
  logic             unused_tgt_lsb;

  // Bit 0 of a jump target is architecturally ignored; bit 1 set means a misaligned target.
  assign eff            = {bus.redirect_target[WIDTH-1:1], 1'b0};
  assign eff_misal      = bus.redirect_target[1];
  assign unused_tgt_lsb = bus.redirect_target[0];

  // Next-state, PC and instruction-register update logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = 1'b0;
    mis_d      = mis_q;
    unique case (state_q)
      StIdle: begin
        if (bus.redirect_valid && eff_misal) begin
          mis_d   = 1'b1;
          state_d = StTrap;
        end else begin
          if (bus.redirect_valid) fetch_pc_d = eff;
          if (bus.fetch_start)    state_d    = StReq;
        end
      end
      StReq: begin
        if (bus.redirect_valid && eff_misal) begin
          mis_d   = 1'b1;
          state_d = StTrap;
        end else if (bus.imem_ack && bus.redirect_valid) begin
          // Jump wins over the returning word: drop the data.
          fetch_pc_d = eff;
          state_d    = StIdle;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PcStep;
          valid_d    = 1'b1;
          state_d    = StIdle;
        end else if (bus.redirect_valid) begin
          pend_d  = eff;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // The outstanding request cannot be withdrawn; wait for its ack and discard it.
        if (bus.redirect_valid && eff_misal) begin
          mis_d   = 1'b1;
          state_d = StTrap;
        end else if (bus.imem_ack) begin
          fetch_pc_d = bus.redirect_valid ? eff : pend_q;
          state_d    = StIdle;
        end else if (bus.redirect_valid) begin
          pend_d = eff;
        end
      end
      StTrap: begin
        state_d = StTrap;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      pend_q     <= '0;
      instr_q    <= Nop;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  // Outputs derived from registered state.
  always_comb begin
    bus.imem_req    = (state_q == StReq) || (state_q == StFlush);
    bus.imem_addr   = fetch_pc_q;
    bus.instr_valid = valid_q;
    bus.instr       = instr_q;
    bus.opcode      = instr_q[6:0];
    bus.instr_pc    = instr_pc_q;
    bus.pc_plus_4   = instr_pc_q + PcStep;
    bus.busy        = (state_q != StIdle);
    bus.misaligned  = mis_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized fetches, waits and redirects
// checked against a transaction-level model of the fetch address and instruction register.
module tb_instr_fetch_unit;
  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  instr_fetch_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: next address to fetch, last delivered word and its address.
  logic [31:0] m_pc, m_instr, m_ipc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_start     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
  endtask

  // Ack the current request in its first cycle and record the delivered word in the model.
  task automatic ack_now(input logic [31:0] data);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack = 1'b0;
    m_instr = data;
    m_ipc   = m_pc;
    m_pc    = m_pc + 32'd4;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_pc    = RESET_PC;
    m_instr = 32'h0000_0013;
    m_ipc   = RESET_PC;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++;
      $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.instr !== 32'h0000_0013) begin n_fail++;
      $display("FAIL reset_instr: got %h want 00000013", bus.instr); end
    n_cmp++; if (bus.opcode !== 7'h13) begin n_fail++;
      $display("FAIL reset_opcode: got %h want 13", bus.opcode); end
    n_cmp++; if (bus.instr_pc !== RESET_PC) begin n_fail++;
      $display("FAIL reset_instr_pc: got %h want %h", bus.instr_pc, RESET_PC); end
    n_cmp++; if (bus.pc_plus_4 !== RESET_PC + 32'd4) begin n_fail++;
      $display("FAIL reset_pc_plus_4: got %h want %h", bus.pc_plus_4, RESET_PC + 32'd4); end
    n_cmp++; if ({bus.instr_valid, bus.busy, bus.misaligned} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.instr_valid, bus.busy, bus.misaligned}); end
    rst = 1'b0;
    m_pc    = RESET_PC;
    m_instr = 32'h0000_0013;
    m_ipc   = RESET_PC;
  endtask

  // Sequential fetches with random wait states and ignored fetch_start pulses.
  task automatic test_basic();
    for (int k = 0; k < 10; k++) begin
      int unsigned waits;
      logic [31:0] data;
      waits = (k == 0) ? 0 : $urandom_range(0, 3);
      data  = (k == 0) ? 32'h0050_0093 : $urandom;
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL basic_issue: got req=%b addr=%h want req=1 addr=%h",
                 bus.imem_req, bus.imem_addr, m_pc); end
      for (int w = 0; w < int'(waits); w++) begin
        bus.fetch_start = 1'($urandom_range(0, 1));
        step();
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.instr_valid !== 1'b0)
        begin
          n_fail++;
          $display("FAIL basic_wait: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                   bus.imem_req, bus.imem_addr, bus.instr_valid, m_pc);
        end
      end
      bus.fetch_start = 1'b0;
      ack_now(data);
      n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++;
        $display("FAIL basic_valid: got %b want 1", bus.instr_valid); end
      n_cmp++; if (bus.instr !== m_instr || bus.opcode !== m_instr[6:0]) begin n_fail++;
        $display("FAIL basic_instr: got %h/%h want %h/%h", bus.instr, bus.opcode,
                 m_instr, m_instr[6:0]); end
      n_cmp++; if (bus.instr_pc !== m_ipc || bus.pc_plus_4 !== m_ipc + 32'd4) begin n_fail++;
        $display("FAIL basic_pc: got %h/%h want %h/%h", bus.instr_pc, bus.pc_plus_4,
                 m_ipc, m_ipc + 32'd4); end
      step();
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++;
        $display("FAIL basic_pulse: got valid=%b req=%b want 0/0",
                 bus.instr_valid, bus.imem_req); end
    end
  endtask

  // Aligned redirects while idle, alone or in the same cycle as fetch_start.
  task automatic test_redirect_idle();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] raw;
      logic [31:0] data;
      raw    = $urandom;
      raw[1] = 1'b0;
      data   = $urandom;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = raw;
      bus.fetch_start     = (i % 2 == 1);
      step();
      bus.redirect_valid = 1'b0;
      if (i % 2 == 0) begin
        n_cmp++; if (bus.busy !== 1'b0 || bus.misaligned !== 1'b0) begin n_fail++;
          $display("FAIL ridle_flags: got busy=%b mis=%b want 0/0", bus.busy, bus.misaligned); end
        bus.fetch_start = 1'b1;
        step();
      end
      bus.fetch_start = 1'b0;
      m_pc = {raw[31:1], 1'b0};
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL ridle_addr: got req=%b addr=%h want 1/%h",
                 bus.imem_req, bus.imem_addr, m_pc); end
      ack_now(data);
      n_cmp++; if (bus.instr !== m_instr || bus.instr_pc !== m_ipc) begin n_fail++;
        $display("FAIL ridle_instr: got %h@%h want %h@%h", bus.instr, bus.instr_pc,
                 m_instr, m_ipc); end
    end
  endtask

  // Redirect during a wait: the late word is discarded; last redirect before the ack wins.
  task automatic test_redirect_wait();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t1, t2, data;
      t1 = (i == 0) ? 32'h0000_0100 : ($urandom & 32'hFFFF_FFFC);
      t2 = $urandom & 32'hFFFF_FFFC;
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      step();
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = t1;
      step();
      bus.redirect_valid = 1'b0;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.busy !== 1'b1)
      begin n_fail++;
        $display("FAIL rwait_hold: got req=%b addr=%h busy=%b want 1/%h/1",
                 bus.imem_req, bus.imem_addr, bus.busy, m_pc); end
      if (i >= 2) begin
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t2;
      end
      step();
      bus.redirect_valid = 1'b0;
      bus.imem_ack       = 1'b1;
      bus.imem_rdata     = 32'hDEAD_BEEF;
      step();
      bus.imem_ack = 1'b0;
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== m_instr || bus.instr_pc !== m_ipc)
      begin n_fail++;
        $display("FAIL rwait_drop: got valid=%b instr=%h pc=%h want 0/%h/%h",
                 bus.instr_valid, bus.instr, bus.instr_pc, m_instr, m_ipc); end
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
        $display("FAIL rwait_idle: got req=%b busy=%b want 0/0", bus.imem_req, bus.busy); end
      m_pc = (i >= 2) ? t2 : t1;
      data = $urandom;
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      n_cmp++; if (bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL rwait_next: got %h want %h", bus.imem_addr, m_pc); end
      ack_now(data);
      n_cmp++; if (bus.instr !== m_instr || bus.instr_valid !== 1'b1) begin n_fail++;
        $display("FAIL rwait_refetch: got %h valid=%b want %h valid=1",
                 bus.instr, bus.instr_valid, m_instr); end
    end
  endtask

  // Redirect and ack in the same cycle: data dropped, bit 0 of the target ignored.
  task automatic test_redirect_ack_same();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] raw;
      raw    = (i == 0) ? 32'h0000_0041 : ($urandom | 32'h1);
      raw[1] = 1'b0;
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start     = 1'b0;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = raw;
      bus.imem_ack        = 1'b1;
      bus.imem_rdata      = $urandom;
      step();
      bus.redirect_valid = 1'b0;
      bus.imem_ack       = 1'b0;
      n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== m_instr || bus.misaligned !== 1'b0)
      begin n_fail++;
        $display("FAIL rsame_drop: got valid=%b instr=%h mis=%b want 0/%h/0",
                 bus.instr_valid, bus.instr, bus.misaligned, m_instr); end
      m_pc = {raw[31:1], 1'b0};
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      n_cmp++; if (bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL rsame_next: got %h want %h", bus.imem_addr, m_pc); end
      ack_now($urandom);
    end
  endtask

  // Fetch at the top of the address space: link value and next PC wrap to zero.
  task automatic test_wrap();
    logic [31:0] data;
    data = $urandom;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    ack_now(data);
    n_cmp++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.pc_plus_4 !== 32'h0) begin n_fail++;
      $display("FAIL wrap_pc: got %h/%h want fffffffc/00000000",
               bus.instr_pc, bus.pc_plus_4); end
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h0 || m_pc !== 32'h0) begin n_fail++;
      $display("FAIL wrap_next: got %h want 00000000", bus.imem_addr); end
    ack_now($urandom);
  endtask

  // Reset while a request is outstanding; a late ack must be ignored.
  task automatic test_reset_mid_fetch();
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_req: got %b want 0", bus.imem_req); end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    step();
    bus.imem_ack = 1'b0;
    m_pc    = RESET_PC;
    m_instr = 32'h0000_0013;
    m_ipc   = RESET_PC;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== m_instr || bus.instr_pc !== m_ipc)
    begin n_fail++;
      $display("FAIL rstmid_late_ack: got valid=%b instr=%h pc=%h want 0/%h/%h",
               bus.instr_valid, bus.instr, bus.instr_pc, m_instr, m_ipc); end
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    n_cmp++; if (bus.imem_addr !== m_pc || bus.imem_req !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_resume: got req=%b addr=%h want 1/%h",
               bus.imem_req, bus.imem_addr, m_pc); end
    ack_now($urandom);
  endtask

  // Misaligned redirect (from idle, then mid-request) traps until reset.
  task automatic test_trap();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] raw;
      raw    = (i == 0) ? 32'h0000_0102 : $urandom;
      raw[1] = 1'b1;
      if (i == 1) begin
        bus.fetch_start = 1'b1;
        step();
        bus.fetch_start = 1'b0;
      end
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = raw;
      step();
      bus.redirect_valid = 1'b0;
      n_cmp++; if (bus.misaligned !== 1'b1 || bus.busy !== 1'b1 || bus.imem_req !== 1'b0)
      begin n_fail++;
        $display("FAIL trap_enter: got mis=%b busy=%b req=%b want 1/1/0",
                 bus.misaligned, bus.busy, bus.imem_req); end
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      step();
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.misaligned !== 1'b1 || bus.busy !== 1'b1)
      begin n_fail++;
        $display("FAIL trap_stuck: got req=%b mis=%b busy=%b want 0/1/1",
                 bus.imem_req, bus.misaligned, bus.busy); end
      apply_reset();
      n_cmp++; if (bus.misaligned !== 1'b0 || bus.busy !== 1'b0 || bus.instr !== m_instr)
      begin n_fail++;
        $display("FAIL trap_clear: got mis=%b busy=%b instr=%h want 0/0/%h",
                 bus.misaligned, bus.busy, bus.instr, m_instr); end
      bus.fetch_start = 1'b1;
      step();
      bus.fetch_start = 1'b0;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin n_fail++;
        $display("FAIL trap_resume: got req=%b addr=%h want 1/%h",
                 bus.imem_req, bus.imem_addr, m_pc); end
      ack_now($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_ack_same();
    test_wrap();
    test_reset_mid_fetch();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
